// File: rtl/lsu_ctrl.sv
// Load/store unit between the core and a word-wide data memory: one request at a time,
// byte/half/word accesses, sub-word stores done as read-modify-write, bad requests rejected early.
module lsu_ctrl #(
  parameter int DEPTH_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } state_e;

  localparam logic [29:0] DEPTH_C = 30'(DEPTH_WORDS);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [31:0] old_q;
  logic [31:0] rsp_rdata_q;
  logic [1:0]  rsp_err_q;

  logic [1:0]  err_d;
  logic [31:0] load_d;
  logic [31:0] merge_d;

  // Priority: illegal funct3, then misalignment, then out-of-range word index.
  function automatic logic [1:0] req_check(input logic we, input logic [2:0] f3,
                                           input logic [31:0] addr);
    logic illegal;
    logic misaligned;
    illegal    = we ? !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)
                    : !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                        f3 == 3'b100 || f3 == 3'b101);
    misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                 ((f3 == 3'b010) && (addr[1:0] != 2'b00));
    if (illegal) begin
      return ERR_ILL;
    end else if (misaligned) begin
      return ERR_ALIGN;
    end else if (addr[31:2] >= DEPTH_C) begin
      return ERR_RANGE;
    end else begin
      return ERR_OK;
    end
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    sh_b = word >> {lane, 3'b000};
    sh_h = word >> {lane[1], 4'b0000};
    case (f3)
      3'b000:  return {{24{sh_b[7]}}, sh_b[7:0]};
      3'b100:  return {24'h000000, sh_b[7:0]};
      3'b001:  return {{16{sh_h[15]}}, sh_h[15:0]};
      3'b101:  return {16'h0000, sh_h[15:0]};
      3'b010:  return word;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] mask;
    logic [31:0] ins;
    case (f3)
      3'b000: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        ins  = {24'h000000, wd[7:0]} << {lane, 3'b000};
        return (old & ~mask) | ins;
      end
      3'b001: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        ins  = {16'h0000, wd[15:0]} << {lane[1], 4'b0000};
        return (old & ~mask) | ins;
      end
      default: return wd;
    endcase
  endfunction

  // Request screening, load extraction and store merge.
  always_comb begin
    err_d   = req_check(req_we, req_funct3, req_addr);
    load_d  = load_extract(funct3_q, addr_q[1:0], mem_rdata);
    merge_d = store_merge(funct3_q, addr_q[1:0], old_q, wdata_q);
  end

  // Control FSM with its latched request and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      funct3_q    <= 3'b000;
      we_q        <= 1'b0;
      old_q       <= 32'h0000_0000;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            if (err_d != ERR_OK) begin
              rsp_err_q   <= err_d;
              rsp_rdata_q <= 32'h0000_0000;
              state_q     <= RSP;
            end else if (req_we && (req_funct3 == 3'b010)) begin
              state_q <= WR;
            end else begin
              state_q <= RD;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RD: begin
          old_q <= mem_rdata;
          if (we_q) begin
            state_q <= WR;
          end else begin
            rsp_rdata_q <= load_d;
            rsp_err_q   <= ERR_OK;
            state_q     <= RSP;
          end
        end
        WR: begin
          rsp_rdata_q <= 32'h0000_0000;
          rsp_err_q   <= ERR_OK;
          state_q     <= RSP;
        end
        RSP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory strobes decode straight from state so an async reset withdraws them immediately.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_we    = (state_q == WR);
  assign mem_addr  = {2'b00, addr_q[31:2]};
  assign mem_wdata = (state_q == WR) ? merge_d : 32'h0000_0000;

endmodule
